// File: rtl/mant_mul_seq.sv
// rtl/mant_mul_seq.sv - iterative shift-and-add significand multiplier built around a 32-bit CLA
// One conditional add per clock; WIDTH RUN cycles per product, valid/ready on both sides.

module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ini_c,
   output logic [31:0] sum,
   output logic        carry
);
   logic [31:0] g;
   logic [31:0] p;
   logic [32:0] c;

   // 4-bit lookahead groups, group carries rippled between groups
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = ini_c;
      for (int k = 0; k < 8; k++) begin
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
      sum   = p ^ c[31:0];
      carry = c[32];
   end
endmodule

module mant_mul_seq #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [4:0] LAST = 5'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH:0]       acc_q, acc_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [31:0]          cla_a, cla_b, cla_sum;
   logic                 cla_carry;
   logic [32:0]          sum_ext;
   logic                 unused_cla;

   // operands are zero-padded, so sum bit WIDTH is the carry of the WIDTH-bit add
   assign cla_a = {{(32-WIDTH){1'b0}}, acc_q[WIDTH-1:0]};
   assign cla_b = mplr_q[0] ? {{(32-WIDTH){1'b0}}, mcand_q} : 32'd0;

   cla32 u_cla (
      .a     (cla_a),
      .b     (cla_b),
      .ini_c (1'b0),
      .sum   (cla_sum),
      .carry (cla_carry)
   );

   assign sum_ext    = {cla_carry, cla_sum};
   assign unused_cla = ^{sum_ext[32:WIDTH+1], acc_q[WIDTH]};

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d = in_a;
               mplr_d  = in_b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d  = {1'b0, sum_ext[WIDTH:1]};
            mplr_d = {sum_ext[0], mplr_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               prod_d  = {sum_ext[WIDTH:0], mplr_q[WIDTH-1:1]};
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // abort wins over any handshake; the last product register is left untouched
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         prod_d  = prod_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_prod  = prod_q;
endmodule
